// File: rtl/counter_x_dev.sv
// counter_x_dev: three-channel programmable down-counter peripheral.
// Each channel has a count, a reload value, a 2-bit mode and a terminal output.
// Optional build macro COUNTER_PRESCALE_EN: channels 1 and 2 tick once every
// PRESCALE clocks from a shared free-running divider. By default every
// channel ticks on every clock.
module counter_x_dev #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned PRESCALE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        counter_we,
    input  logic [31:0] counter_val,
    input  logic [1:0]  counter_set,
    output logic        counter0_out,
    output logic        counter1_out,
    output logic        counter2_out,
    output logic [31:0] counter_out
);

    localparam int unsigned NUM_CH      = 3;
    localparam logic [1:0]  MODE_ONESHOT = 2'b00;
    localparam logic [1:0]  MODE_RATE    = 2'b01;
    localparam logic [1:0]  MODE_SQUARE  = 2'b10;
    localparam logic [1:0]  MODE_HALT    = 2'b11;
    localparam logic [1:0]  SET_CTRL     = 2'b11;

    logic [CNT_W-1:0] count_q  [NUM_CH];
    logic [CNT_W-1:0] count_d  [NUM_CH];
    logic [CNT_W-1:0] reload_q [NUM_CH];
    logic [CNT_W-1:0] reload_d [NUM_CH];
    logic [1:0]       mode_q   [NUM_CH];
    logic [1:0]       mode_d   [NUM_CH];
    logic [2:0]       out_q;
    logic [2:0]       out_d;
    logic [2:0]       tick;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             div_tick;

    // Free-running divider shared by channels 1 and 2; only reset clears it
    always_comb begin
        div_tick = (div_q == DIV_W'(PRESCALE - 1));
        div_d    = div_tick ? '0 : div_q + DIV_W'(1);
    end

    // Divider register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

    assign tick = {div_tick, div_tick, 1'b1};
`else
    localparam int unsigned UNUSED_PRESCALE = PRESCALE;

    assign tick = 3'b111;
`endif

    // Next state per channel: tick/terminal handling, then load, then control write
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            count_d[i]  = count_q[i];
            reload_d[i] = reload_q[i];
            mode_d[i]   = mode_q[i];
            out_d[i]    = out_q[i];

            // Rate pulse lasts exactly one clock while the channel is running
            if (mode_q[i] == MODE_RATE && count_q[i] != '0) begin
                out_d[i] = 1'b0;
            end

            if (tick[i] && mode_q[i] != MODE_HALT && count_q[i] != '0) begin
                if (count_q[i] == CNT_W'(1)) begin
                    case (mode_q[i])
                        MODE_ONESHOT: begin
                            count_d[i] = '0;
                            out_d[i]   = 1'b1;
                        end
                        MODE_RATE: begin
                            count_d[i] = reload_q[i];
                            out_d[i]   = 1'b1;
                        end
                        MODE_SQUARE: begin
                            count_d[i] = reload_q[i];
                            out_d[i]   = ~out_q[i];
                        end
                        default: ;
                    endcase
                end else begin
                    count_d[i] = count_q[i] - CNT_W'(1);
                end
            end

            // A load on the terminal edge overrides reload and toggle
            if (counter_we && counter_set == 2'(i)) begin
                count_d[i]  = counter_val[CNT_W-1:0];
                reload_d[i] = counter_val[CNT_W-1:0];
                out_d[i]    = 1'b0;
            end

            // Mode change takes effect from the next tick; channel field 3 matches nothing
            if (counter_we && counter_set == SET_CTRL && counter_val[25:24] == 2'(i)) begin
                mode_d[i] = counter_val[1:0];
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i]  <= '0;
                reload_q[i] <= '0;
                mode_q[i]   <= MODE_HALT;
            end
            out_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i]  <= count_d[i];
                reload_q[i] <= reload_d[i];
                mode_q[i]   <= mode_d[i];
            end
            out_q <= out_d;
        end
    end

    assign counter0_out = out_q[0];
    assign counter1_out = out_q[1];
    assign counter2_out = out_q[2];

    // Readback: selected channel count, or the three terminal outputs
    always_comb begin
        counter_out = '0;
        case (counter_set)
            2'b00:   counter_out = 32'(count_q[0]);
            2'b01:   counter_out = 32'(count_q[1]);
            2'b10:   counter_out = 32'(count_q[2]);
            default: counter_out = {29'b0, out_q};
        endcase
    end

endmodule

// File: tb/tb_counter_x_dev.sv
// Scoreboard bench for counter_x_dev in its default build (no prescaler).
// Stimulus pushes expected {counter_out, outputs} after each edge; a monitor
// pops and compares shortly after every rising edge.
module tb_counter_x_dev;

    logic        clk;
    logic        rst;
    logic        counter_we;
    logic [31:0] counter_val;
    logic [1:0]  counter_set;
    logic        counter0_out;
    logic        counter1_out;
    logic        counter2_out;
    logic [31:0] counter_out;

    typedef struct packed {
        logic [31:0] cnt;
        logic [2:0]  outs;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    counter_x_dev #(.CNT_W(32), .PRESCALE(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .counter_we   (counter_we),
        .counter_val  (counter_val),
        .counter_set  (counter_set),
        .counter0_out (counter0_out),
        .counter1_out (counter1_out),
        .counter2_out (counter2_out),
        .counter_out  (counter_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation against the settled outputs
    always begin
        exp_t  e;
        string nm;
        @(posedge clk);
        #2;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (counter_out !== e.cnt) begin
                errors++;
                $display("FAIL %s: counter_out=%0d expected %0d", nm, counter_out, e.cnt);
            end
            checks++;
            if ({counter2_out, counter1_out, counter0_out} !== e.outs) begin
                errors++;
                $display("FAIL %s: outs=%b expected %b", nm,
                         {counter2_out, counter1_out, counter0_out}, e.outs);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_out(input string nm, input logic [31:0] cnt, input logic [2:0] outs);
        exp_t e;
        e.cnt  = cnt;
        e.outs = outs;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sel_step(input logic [1:0] s);
        @(negedge clk);
        counter_set = s;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] s, input logic [31:0] v);
        @(negedge clk);
        counter_we  = 1'b1;
        counter_set = s;
        counter_val = v;
        @(posedge clk);
        #1;
        counter_we = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        logic p;
        rst         = 1'b1;
        counter_we  = 1'b0;
        counter_val = '0;
        counter_set = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        expect_out("reset", 32'd0, 3'b000);

        // Channel 0 one-shot, load 10
        wr(2'b11, 32'h0000_0000);
        wr(2'b00, 32'd10);
        expect_out("os_load", 32'd10, 3'b000);
        for (int k = 1; k <= 10; k++) begin
            step();
            expect_out($sformatf("os_k%0d", k), 32'(10 - k), (k == 10) ? 3'b001 : 3'b000);
        end
        repeat (3) begin
            step();
            expect_out("os_hold", 32'd0, 3'b001);
        end

        // Channel 1 rate, load 4
        wr(2'b11, 32'h0100_0001);
        wr(2'b01, 32'd4);
        expect_out("rate_load", 32'd4, 3'b001);
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_cnt = (k % 4 == 0) ? 4 : 4 - (k % 4);
            p = (k % 4 == 0);
            expect_out($sformatf("rate_k%0d", k), 32'(exp_cnt), {1'b0, p, 1'b1});
        end

        // Load of 0 idles channel 1
        wr(2'b01, 32'd0);
        expect_out("load0", 32'd0, 3'b001);
        repeat (5) begin
            step();
            expect_out("load0_idle", 32'd0, 3'b001);
        end

        // Channel 2 square, load 3
        wr(2'b11, 32'h0200_0002);
        expect_out("ctrl_rb", 32'd1, 3'b001);
        wr(2'b10, 32'd3);
        expect_out("sq_load", 32'd3, 3'b001);
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_cnt = (k % 3 == 0) ? 3 : 3 - (k % 3);
            p = ((k / 3) % 2) == 1;
            expect_out($sformatf("sq_k%0d", k), 32'(exp_cnt), {p, 2'b01});
        end

        // Halt channel 2: the write edge still decrements, then it freezes at 2
        wr(2'b11, 32'h0200_0003);
        expect_out("halt_rb", 32'd1, 3'b001);
        sel_step(2'b10);
        expect_out("halt_frz", 32'd2, 3'b001);
        repeat (4) begin
            step();
            expect_out("halt_frz", 32'd2, 3'b001);
        end

        // Resume square mode from the frozen count
        wr(2'b11, 32'h0200_0002);
        expect_out("resume_rb", 32'd1, 3'b001);
        sel_step(2'b10);
        expect_out("resume_1", 32'd1, 3'b001);
        step();
        expect_out("resume_term", 32'd3, 3'b101);
        sel_step(2'b11);
        expect_out("rb_outs", 32'd5, 3'b101);
        wr(2'b11, 32'h0200_0003);
        expect_out("halt2_rb", 32'd5, 3'b101);

        // Control with channel field 3 must not touch any channel
        wr(2'b11, 32'h0300_0000);
        expect_out("ch3_rb", 32'd5, 3'b101);
        sel_step(2'b10);
        expect_out("ch3_ign", 32'd1, 3'b101);
        repeat (3) begin
            step();
            expect_out("ch3_ign", 32'd1, 3'b101);
        end

        // Channel 0 rate, load 2, then reload 7 on the terminal edge
        wr(2'b11, 32'h0000_0001);
        expect_out("rate0_rb", 32'd5, 3'b101);
        wr(2'b00, 32'd2);
        expect_out("lt_load", 32'd2, 3'b100);
        step();
        expect_out("lt_1", 32'd1, 3'b100);
        wr(2'b00, 32'd7);
        expect_out("lt_win", 32'd7, 3'b100);
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_cnt = (k == 7) ? 7 : (k == 8) ? 6 : 7 - k;
            expect_out($sformatf("lt_k%0d", k), 32'(exp_cnt), (k == 7) ? 3'b101 : 3'b100);
        end

        // Short asynchronous reset pulse between rising edges
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        expect_out("async_rst", 32'd0, 3'b000);
        for (int k = 0; k < 20; k++) begin
            step();
            expect_out("rst_quiet", 32'd0, 3'b000);
        end
        sel_step(2'b11);
        expect_out("rst_rb", 32'd0, 3'b000);

        // Mode resets to halt: a load does not start counting
        wr(2'b00, 32'd5);
        expect_out("rst_halt", 32'd5, 3'b000);
        repeat (3) begin
            step();
            expect_out("rst_halt", 32'd5, 3'b000);
        end

        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_x_dev.md
# counter_x_dev

Three-channel programmable down-counter peripheral fed directly by the GPIO output port. The GPIO register drives `counter_set`, which selects the target of each bus write: channel 0, 1 or 2 reload value, or the control word. The CPU writes reload values and modes through the memory-mapped counter port. Each channel raises a terminal output used for delays, periodic interrupts or square-wave generation. The current count is readable back on `counter_out`.

## Interface
- `CNT_W`, 32, counter and reload width per channel (8..32).
- `PRESCALE`, 16, divide ratio of the channel 1/2 tick when prescaling is compiled in (≥2).
- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `counter_we` in 1: write strobe for the counter port; one write per asserted cycle.
- `counter_val` in 32: write data; low `CNT_W` bits are reload data; `[25:24]` is the channel field and `[1:0]` is the mode field of a control word.
- `counter_set` in 2: write target from GPIO: `00` ch0 load, `01` ch1 load, `10` ch2 load, `11` control word.
- `counter0_out`, `counter1_out`, `counter2_out` out 1: per-channel terminal outputs, registered.
- `counter_out` out 32: combinational readback. For `counter_set` = 0..2 it is the zero-extended count of that channel. For `11` it is `{29'b0, counter2_out, counter1_out, counter0_out}`.

## Operation
- State per channel: `count`, `reload` (both `CNT_W`), `mode` (2 bits), `out`.
- Reset values: all `count` = 0, all `reload` = 0, all `mode` = `11` (halted), all outputs 0. After reset, `counter_out` = 0.
- **Load write** (`counter_we`, `counter_set`=n<3):
  - `reload[n]` and `count[n]` are set to `counter_val[CNT_W-1:0]`.
  - `out[n]` is cleared to 0.
  - `mode[n]` is unchanged.
- **Control write** (`counter_we`, `counter_set`=11):
  - `mode[counter_val[25:24]]` is set to `counter_val[1:0]`.
  - `count` and `out` are unchanged.
  - A channel field of 3 makes the write ignored.
- **Running**: a channel runs when `mode`≠11 and `count`≠0. It decrements on each of its ticks.
  - Channel 0 ticks every clk.
  - Channels 1 and 2 tick per the Configuration section.
- **Terminal tick**: a tick on which `count`==1.
  - Mode `00` one-shot: `count` goes to 0 and `out` goes to 1. `out` holds until the next load; the channel then stops.
  - Mode `01` rate: `count` is reloaded from `reload` and `out` is 1 for exactly one clk.
  - Mode `10` square: `count` is reloaded and `out` toggles.
  - Mode `11` halt: `count` and `out` are frozen. A control write to `00`/`01`/`10` resumes from the frozen count.
- Load of 0: the channel idles with `count`=0; no terminal event occurs and `out` stays 0.
- Load of 1 in rate mode: `out` is high every clk after the first (period 1).

## Timing
- Write takes effect on the rising edge where `counter_we`=1. The first decrement occurs on the next tick.
- Load N at edge t in one-shot or rate mode (channel 0): the terminal event occurs at edge t+N, and `out` is visible after that edge.
- Rate mode period is N clk. Square mode period is 2N clk, with 50% duty.
- Load on the same edge as that channel's terminal tick: the load wins. The result is `count`=new value and `out`=0, with no reload and no toggle.
- Control write on a terminal edge: the tick completes under the old mode, and the new mode applies from the next tick.
- `counter_set` changes on the opposite clock edge from GPIO and is stable at the rising edge. No synchronizer is required.
- Assertion of `rst` at any time returns all state to reset values immediately.

## Configuration
- `COUNTER_PRESCALE_EN` defined:
  - Channels 1 and 2 tick once every `PRESCALE` clk from a shared free-running divider.
  - The divider is reset to 0 by `rst` only and is not affected by loads.
- `COUNTER_PRESCALE_EN` undefined:
  - No divider is instantiated.
  - All three channels tick every clk.

## Test plan
- **Reset behaviour**: assert `rst` mid-count with ch0 rate mode loaded 5 → all outputs 0 and `counter_out`=0. With no further writes, nothing changes for 20 clk.
- **Ch0 one-shot**: control `{ch0, 00}`, then load 10 → `counter0_out` rises after the 10th following edge and stays high. Reading with `counter_set`=00 shows 10, 9, …, 0.
- **Ch1 rate**: control `{ch1, 01}`, then load 4 → `counter1_out` is a single-cycle pulse every 4 clk (every 64 clk with `COUNTER_PRESCALE_EN`, `PRESCALE`=16).
- **Ch2 square**: control `{ch2, 10}`, then load 3 → `counter2_out` toggles every 3 clk, period 6.
  - Halt via `{ch2, 11}` → count freezes.
  - Resume → the remaining count continues.
- **Load on terminal edge**: ch0 in rate mode loaded 2; reload with 7 exactly on the terminal edge → no pulse; the next pulse comes 7 clk later.
- **Boundaries**:
  - Load 0 → no events.
  - Control with channel field 3 → no state change.
  - `counter_set`=11 readback reflects the three `out` bits.
